instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_req  output  1  fetch request to instruction memory; registered.
REQ-005 imem_addr  output  32  fetch address; registered; always word-aligned.
REQ-006 imem_ack  input  1  memory returns imem_rdata this cycle; ignored while imem_req=0.
REQ-007 imem_rdata  input  32  instruction word; sampled only when imem_req=1 and imem_ack=1.
REQ-008 instr_valid  output  1  instr, imm16 and pc hold a fetched instruction.
REQ-009 instr_ready  input  1  consumer accepts the instruction; transfer occurs when instr_valid=1 and instr_ready=1.
REQ-010 instr  output  32  instruction register (IR).
REQ-011 imm16  output  16  IR[15:0], feeding the immediate extender.
REQ-012 pc  output  32  address of the instruction held in IR.
REQ-013 npc_op  input  2  next-PC select at transfer: 00 sequential, 01 branch, 10 jump, 11 register jump.
REQ-014 branch_taken  input  1  qualifies npc_op=01.
REQ-015 imm32  input  32  extended immediate, word offset for branches.
REQ-016 jr_target  input  32  register-jump target.

Function
REQ-017 FSM states: IDLE, FETCH, HOLD; encoding is free.
REQ-018 IDLE: imem_req=0, instr_valid=0; next state FETCH unconditionally.
REQ-019 FETCH: imem_req=1, imem_addr=fetch PC, instr_valid=0; on imem_ack=1, load IR from imem_rdata and pc from fetch PC, then go to HOLD; otherwise remain in FETCH with address unchanged.
REQ-020 HOLD: imem_req=0, instr_valid=1; IR and pc stable until transfer.
REQ-021 On transfer in HOLD, fetch PC is computed per REQ-022, the block enters FETCH next cycle, and instr_valid drops.
REQ-022 Next PC, with P=pc+4 (mod 2^32):
- 00: P.
- 01, branch_taken=1: P+(imm32<<2).
- 01, branch_taken=0: P.
- 10: {P[31:28], instr[25:0], 2'b00}.
- 11: {jr_target[31:2], 2'b00}.
REQ-023 Adders are 32-bit, and carry-out is discarded; 32'hFFFF_FFFC sequential wraps to 32'h0000_0000.
REQ-024 npc_op, branch_taken, imm32 and jr_target are sampled only in the transfer cycle.
REQ-025 Latency: imem_ack in cycle N gives instr_valid=1 in cycle N+1; transfer in cycle M gives imem_req=1 with new address in cycle M+1.
REQ-026 instr_ready while not in HOLD has no effect.
REQ-027 At most one outstanding request; imem_addr never changes while imem_req=1 and imem_ack=0.

Reset
REQ-028 rst=1 at a clock edge forces IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, pc=0, fetch PC=RESET_PC; this applies in every state and overrides all other inputs that cycle.
REQ-029 Reset during FETCH abandons the request; an imem_ack arriving in the cycle rst is high or the cycle after is ignored and never loaded into IR.
REQ-030 First fetch after rst deasserts: IDLE for one cycle, then FETCH at RESET_PC.

Verification
REQ-031 Reset, then ack after 0 and 3 wait cycles: imem_req at RESET_PC; instr_valid one cycle after ack; instr=rdata; pc=32'h3000; imm16=rdata[15:0].
REQ-032 Back-to-back sequential with instr_ready held 1: pc sequence 3000, 3004, 3008; one instr_valid pulse per ack.
REQ-033 Branch at pc=32'h3010, taken, imm32=32'hFFFF_FFFC: next fetch 32'h3004. Same case not taken: next fetch 32'h3014.
REQ-034 Jump with instr=32'h0800_0C40 at pc=32'h3000: next fetch 32'h0000_3100. Register jump with jr_target=32'h0000_4003: next fetch 32'h0000_4000.
REQ-035 Backpressure: instr_ready=0 for 5 cycles in HOLD keeps instr, pc and instr_valid stable with imem_req=0; imem_ack pulses during that time are ignored.
REQ-036 rst asserted mid-FETCH with imem_ack in the same cycle: IR stays 0, instr_valid stays 0, and the next request goes to RESET_PC; also check the sequential wrap from 32'hFFFF_FFFC to 0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with a single outstanding memory request.
//
// The unit holds one instruction at a time. It requests a word from
// instruction memory, captures it into the instruction register (IR), and
// presents it downstream until the consumer accepts it. The next fetch
// address is then chosen from the next-PC controls.
//
// Ports:
//   clk          sole clock; all state updates on the rising edge
//   rst          synchronous active-high reset
//   imem_req     registered fetch request to instruction memory
//   imem_addr    registered, word-aligned fetch address
//   imem_ack     memory returns imem_rdata this cycle (ignored while imem_req=0)
//   imem_rdata   instruction word from memory
//   instr_valid  instr / imm16 / pc hold a fetched instruction
//   instr_ready  consumer accepts the instruction when instr_valid=1
//   instr        instruction register
//   imm16        IR[15:0], fed to the immediate extender
//   pc           address of the instruction held in IR
//   npc_op       next-PC select: 00 seq, 01 branch, 10 jump, 11 register jump
//   branch_taken qualifies a branch
//   imm32        extended immediate, word offset for branches
//   jr_target    register-jump target
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [15:0] imm16,
    output logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic        branch_taken,
    input  logic [31:0] imm32,
    input  logic [31:0] jr_target
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t state;

    // Next fetch address for the instruction in IR. All additions are plain
    // 32-bit and wrap; the branch offset is a signed word count, so shifting
    // it left by two and adding modulo 2^32 handles negative offsets.
    function automatic logic [31:0] next_pc(
        input logic [31:0] cur_pc,
        input logic [31:0] ir,
        input logic [1:0]  op,
        input logic        taken,
        input logic [31:0] imm,
        input logic [31:0] jr
    );
        logic        [31:0] seq;
        logic signed [31:0] offset;
        logic        [31:0] result;
        seq    = cur_pc + 32'd4;
        offset = $signed(imm) <<< 2;
        case (op)
            2'b01:   result = taken ? (seq + $unsigned(offset)) : seq;
            2'b10:   result = (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
            2'b11:   result = jr & 32'hFFFF_FFFC;
            default: result = seq;
        endcase
        return result;
    endfunction

    assign imm16 = instr[15:0];

    // imem_addr doubles as the fetch PC: it is only updated when a new request
    // is launched, so it never moves while a request is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'd0;
            pc          <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        state       <= HOLD;
                        imem_req    <= 1'b0;
                        instr       <= imem_rdata;
                        pc          <= imem_addr;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                        imem_addr   <= next_pc(pc, instr, npc_op, branch_taken,
                                               imm32, jr_target);
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [15:0] imm16;
    logic [31:0] pc;
    logic [1:0]  npc_op;
    logic        branch_taken;
    logic [31:0] imm32;
    logic [31:0] jr_target;

    int vectors = 0;
    int miscompares = 0;

    instr_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .imm16(imm16), .pc(pc),
        .npc_op(npc_op), .branch_taken(branch_taken),
        .imm32(imm32), .jr_target(jr_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int          waits;
        bit          hold_rdy;
        logic [31:0] exp_pc;
        logic [1:0]  op;
        bit          bt;
        logic [31:0] imm;
        logic [31:0] jr;
        logic [31:0] exp_next;
    } vec_t;

    vec_t tbl[10];

    // Reference next-PC, straight from the arithmetic rules.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ir,
                                             input logic [1:0] op, input bit bt,
                                             input logic [31:0] imm, input logic [31:0] jr);
        logic [31:0] p;
        p = cur + 32'd4;
        if (op == 2'd1 && bt) return p + imm * 32'd4;
        if (op == 2'd2)       return (p & 32'hF000_0000) + (ir % 32'h0400_0000) * 32'd4;
        if (op == 2'd3)       return jr - (jr % 32'd4);
        return p;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Enter with the DUT in FETCH at exp_pc; leave one cycle after the ack.
    task automatic do_fetch(input logic [31:0] rd, input int waits, input bit rdy,
                            input logic [31:0] exp_pc);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            instr_ready = rdy;
            imem_ack    = 1'b0;
            imem_rdata  = $urandom;
            cyc();
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, exp_pc);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        instr_ready = rdy;
        imem_ack    = 1'b1;
        imem_rdata  = rd;
        cyc();
        imem_ack    = 1'b0;
        imem_rdata  = $urandom;
        chk("ack_valid", {31'd0, instr_valid}, 32'd1);
        chk("ack_instr", instr, rd);
        chk("ack_pc", pc, exp_pc);
        chk("ack_imm16", {16'd0, imm16}, {16'd0, rd[15:0]});
        chk("ack_req", {31'd0, imem_req}, 32'd0);
    endtask

    // Stall in HOLD with ack noise; IR, pc and valid must not move.
    task automatic hold_cycles(input int n, input logic [31:0] exp_ir, input logic [31:0] exp_pc);
        for (int i = 0; i < n; i++) begin
            instr_ready = 1'b0;
            imem_ack    = (i % 2 == 0);
            imem_rdata  = $urandom;
            cyc();
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_instr", instr, exp_ir);
            chk("hold_pc", pc, exp_pc);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
        end
        imem_ack = 1'b0;
    endtask

    task automatic transfer(input logic [1:0] op, input bit bt, input logic [31:0] imm,
                            input logic [31:0] jr, input logic [31:0] exp_next);
        npc_op       = op;
        branch_taken = bt;
        imm32        = imm;
        jr_target    = jr;
        instr_ready  = 1'b1;
        cyc();
        instr_ready  = 1'b0;
        npc_op       = 2'($urandom);
        branch_taken = 1'($urandom);
        imm32        = $urandom;
        jr_target    = $urandom;
        chk("xfer_valid", {31'd0, instr_valid}, 32'd0);
        chk("xfer_req", {31'd0, imem_req}, 32'd1);
        chk("xfer_addr", imem_addr, exp_next);
    endtask

    initial begin
        logic [31:0] cur, rd, nxt, jr, imm;
        logic [1:0]  op;
        bit          bt;

        tbl[0] = '{32'h1111_1111, 0, 1'b0, 32'h3000, 2'd0, 1'b0, 32'd0,         32'd0,         32'h3004};
        tbl[1] = '{32'h2222_2222, 3, 1'b1, 32'h3004, 2'd0, 1'b0, 32'd0,         32'd0,         32'h3008};
        tbl[2] = '{32'h3333_3333, 0, 1'b1, 32'h3008, 2'd0, 1'b0, 32'd0,         32'd0,         32'h300C};
        tbl[3] = '{32'h4444_ABCD, 1, 1'b0, 32'h300C, 2'd0, 1'b0, 32'd0,         32'd0,         32'h3010};
        tbl[4] = '{32'h1000_FFFF, 2, 1'b0, 32'h3010, 2'd1, 1'b1, 32'hFFFF_FFFC, 32'd0,         32'h3004};
        tbl[5] = '{32'h5555_5555, 0, 1'b0, 32'h3004, 2'd3, 1'b0, 32'd0,         32'h0000_3010, 32'h3010};
        tbl[6] = '{32'h1000_FFFF, 0, 1'b0, 32'h3010, 2'd1, 1'b0, 32'hFFFF_FFFC, 32'd0,         32'h3014};
        tbl[7] = '{32'h6666_6666, 1, 1'b0, 32'h3014, 2'd3, 1'b0, 32'd0,         32'h0000_3000, 32'h3000};
        tbl[8] = '{32'h0800_0C40, 0, 1'b0, 32'h3000, 2'd2, 1'b0, 32'd0,         32'd0,         32'h3100};
        tbl[9] = '{32'h7777_7777, 3, 1'b0, 32'h3100, 2'd3, 1'b0, 32'd0,         32'h0000_4003, 32'h4000};

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        npc_op = 2'd0; branch_taken = 1'b0; imm32 = 32'd0; jr_target = 32'd0;
        cyc();
        cyc();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h3000);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 10; i++) begin
            do_fetch(tbl[i].rdata, tbl[i].waits, tbl[i].hold_rdy, tbl[i].exp_pc);
            transfer(tbl[i].op, tbl[i].bt, tbl[i].imm, tbl[i].jr, tbl[i].exp_next);
        end

        // Backpressure for five cycles with stray acks.
        do_fetch(32'h8888_1234, 1, 1'b0, 32'h4000);
        hold_cycles(5, 32'h8888_1234, 32'h4000);
        transfer(2'd0, 1'b0, 32'd0, 32'd0, 32'h4004);

        // Reset mid-FETCH with a simultaneous ack, and an ack the cycle after.
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        rst = 1'b0;
        chk("rstf_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstf_instr", instr, 32'd0);
        chk("rstf_req", {31'd0, imem_req}, 32'd0);
        chk("rstf_addr", imem_addr, 32'h3000);
        cyc();
        imem_ack = 1'b0;
        chk("rstf2_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstf2_instr", instr, 32'd0);
        chk("rstf2_req", {31'd0, imem_req}, 32'd1);
        chk("rstf2_addr", imem_addr, 32'h3000);

        // Sequential wrap at the top of the address space.
        do_fetch(32'h9999_9999, 0, 1'b0, 32'h3000);
        transfer(2'd3, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        do_fetch(32'hAAAA_AAAA, 2, 1'b0, 32'hFFFF_FFFC);
        transfer(2'd0, 1'b0, 32'd0, 32'd0, 32'h0000_0000);

        // Randomized traffic against the reference model.
        cur = 32'h0000_0000;
        for (int n = 0; n < 200; n++) begin
            rd = $urandom;
            do_fetch(rd, $urandom_range(0, 3), 1'($urandom_range(0, 1)), cur);
            hold_cycles($urandom_range(0, 2), rd, cur);
            op  = 2'($urandom);
            bt  = 1'($urandom);
            imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom;
            jr  = $urandom;
            nxt = ref_next(cur, rd, op, bt, imm, jr);
            transfer(op, bt, imm, jr, nxt);
            cur = nxt;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
